axi_ram_slave: RTL and testbench

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

---
 rtl/axi_ram_slave_if.sv | 55 +++++
 rtl/axi_ram_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_ram_slave_if.sv
// AXI subordinate-side bundle (AW, W, B, AR, R) used by axi_ram_slave.
interface axi_if #(
  parameter int unsigned ID_W_WIDTH = 4,
  parameter int unsigned ID_R_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  // Write address channel
  logic [ID_W_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [ID_W_WIDTH-1:0]   bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [ID_R_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [ID_R_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport s (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_ram_slave.sv
// AXI RAM subordinate: independent write and read FSMs over one shared word array.
// Word index is (addr / bytes-per-word) mod MEM_DEPTH; out-of-range addresses alias.
// Optional macro AXI_RAM_SLAVE_MEM_RESET_EN: ARESETn also clears every memory word.
module axi_ram_slave #(
  parameter int unsigned ID_W_WIDTH     = 4,
  parameter int unsigned ID_R_WIDTH     = 4,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH      = 256
) (
  input logic ACLK,
  input logic ARESETn,
  axi_if.s    s
);

  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int unsigned BYTE_SHIFT = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  // FIXED holds the address; INCR, WRAP and reserved all advance by the beat size.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [2:0]            size,
                                                     input logic [1:0]            burst);
    if (burst == 2'b00) return a;
    return a + (ADDR_WIDTH'(1) << size);
  endfunction

  function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_WIDTH'(a >> BYTE_SHIFT);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Write side state
  w_state_e              w_state_q, w_state_d;
  logic [ID_W_WIDTH-1:0] w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [2:0]            w_size_q, w_size_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  w_we;
  logic                  awready, wready, bvalid;

  // Read side state
  r_state_e              r_state_q, r_state_d;
  logic [ID_R_WIDTH-1:0] r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  arready, rvalid, rlast;

  // Termination is by beat count only, so WLAST is deliberately ignored.
  logic unused_wlast;
  assign unused_wlast = s.wlast;

  // Write FSM next-state and handshake outputs
  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_cnt_d   = w_cnt_q;
    w_we      = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        awready = 1'b1;
        if (s.awvalid) begin
          w_id_d    = s.awid;
          w_addr_d  = s.awaddr;
          w_len_d   = s.awlen;
          w_size_d  = s.awsize;
          w_burst_d = s.awburst;
          w_cnt_d   = 8'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (s.wvalid) begin
          w_we     = 1'b1;
          w_cnt_d  = w_cnt_q + 8'd1;
          w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
          if (w_cnt_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (s.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_cnt_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_cnt_q   <= w_cnt_d;
    end
  end

  // Read FSM next-state and handshake outputs
  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_cnt_d   = r_cnt_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (s.arvalid) begin
          r_id_d    = s.arid;
          r_addr_d  = s.araddr;
          r_len_d   = s.arlen;
          r_size_d  = s.arsize;
          r_burst_d = s.arburst;
          r_cnt_d   = 8'd0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_cnt_q == r_len_q);
        if (s.rready) begin
          r_cnt_d  = r_cnt_q + 8'd1;
          r_addr_d = next_addr(r_addr_q, r_size_q, r_burst_q);
          if (rlast) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read FSM state register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

`ifdef AXI_RAM_SLAVE_MEM_RESET_EN
  // Byte-masked memory write; reset clears the whole array
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= '0;
    end else if (w_we) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (s.wstrb[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= s.wdata[b*8 +: 8];
      end
    end
  end
`else
  // Byte-masked memory write; array contents are not reset
  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int b = 0; b < int'(STRB_WIDTH); b++) begin
        if (s.wstrb[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= s.wdata[b*8 +: 8];
      end
    end
  end
`endif

  // Asynchronous read gives pre-write data when a write hits the same word this cycle.
  assign s.rdata   = mem[word_idx(r_addr_q)];
  assign s.rid     = r_id_q;
  assign s.rresp   = 2'b00;
  assign s.rvalid  = rvalid;
  assign s.rlast   = rlast;
  assign s.arready = arready;
  assign s.awready = awready;
  assign s.wready  = wready;
  assign s.bvalid  = bvalid;
  assign s.bid     = w_id_q;
  assign s.bresp   = 2'b00;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed self-checking bench for axi_ram_slave.
module tb_axi_ram_slave;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [31:0] wd   [16];
  logic [31:0] rexp [16];

  axi_if #(
    .ID_W_WIDTH(4),
    .ID_R_WIDTH(4),
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32)
  ) bus ();

  axi_ram_slave #(
    .ID_W_WIDTH    (4),
    .ID_R_WIDTH    (4),
    .ADDR_WIDTH    (16),
    .AXI_DATA_WIDTH(32),
    .MEM_DEPTH     (256)
  ) dut (
    .ACLK   (clk),
    .ARESETn(rst_n),
    .s      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [3:0] strb);
    bus.awid    = id;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awsize  = 3'd2;
    bus.awburst = burst;
    bus.awvalid = 1'b1;
    check("awready_idle", 32'(bus.awready), 32'd1);
    tick();
    bus.awvalid = 1'b0;
    check("awready_busy", 32'(bus.awready), 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = wd[i];
      bus.wstrb  = strb;
      // WLAST asserted on beat 0 only; the DUT must count beats instead
      bus.wlast  = (i == 0);
      check("wready_data", 32'(bus.wready), 32'd1);
      check("bvalid_data", 32'(bus.bvalid), 32'd0);
      tick();
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    check("bvalid_resp", 32'(bus.bvalid), 32'd1);
    check("bid", 32'(bus.bid), 32'(id));
    check("wready_resp", 32'(bus.wready), 32'd0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("bvalid_done", 32'(bus.bvalid), 32'd0);
    check("awready_done", 32'(bus.awready), 32'd1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int stall_beat);
    bus.arid    = id;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arsize  = 3'd2;
    bus.arburst = burst;
    bus.arvalid = 1'b1;
    check("arready_idle", 32'(bus.arready), 32'd1);
    tick();
    bus.arvalid = 1'b0;
    check("arready_busy", 32'(bus.arready), 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        bus.rready = 1'b0;
        repeat (5) begin
          check("stall_rvalid", 32'(bus.rvalid), 32'd1);
          check("stall_rdata", bus.rdata, rexp[i]);
          check("stall_rlast", 32'(bus.rlast), 32'(i == int'(len)));
          tick();
        end
      end
      bus.rready = 1'b1;
      check("rvalid", 32'(bus.rvalid), 32'd1);
      check("rdata", bus.rdata, rexp[i]);
      check("rid", 32'(bus.rid), 32'(id));
      check("rlast", 32'(bus.rlast), 32'(i == int'(len)));
      tick();
    end
    bus.rready = 1'b0;
    check("rvalid_done", 32'(bus.rvalid), 32'd0);
    check("arready_done", 32'(bus.arready), 32'd1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_awready", 32'(bus.awready), 32'd1);
    check("rst_arready", 32'(bus.arready), 32'd1);
    check("rst_wready", 32'(bus.wready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rlast", 32'(bus.rlast), 32'd0);
    check("rst_bid", 32'(bus.bid), 32'd0);
    check("rst_rid", 32'(bus.rid), 32'd0);
    rst_n = 1'b1;
    tick();

    // W beat offered before AW must stall, then be taken once AW is accepted
    bus.wvalid = 1'b1;
    bus.wdata  = 32'h0000_00A0;
    bus.wstrb  = 4'hF;
    check("w_before_aw_wready", 32'(bus.wready), 32'd0);
    tick();
    check("w_before_aw_wready2", 32'(bus.wready), 32'd0);
    bus.wvalid = 1'b0;

    // INCR burst of 4 at 0x10, ID 3
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    do_write(4'd3, 16'h0010, 8'd3, 2'b01, 4'hF);
    rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
    do_read(4'd5, 16'h0010, 8'd3, 2'b01, -1);

    // Byte strobes: 0xFFFFFFFF then 0x11223344 with strobe 0101
    wd[0] = 32'hFFFF_FFFF;
    do_write(4'd1, 16'h0020, 8'd0, 2'b01, 4'hF);
    wd[0] = 32'h1122_3344;
    do_write(4'd2, 16'h0020, 8'd0, 2'b01, 4'b0101);
    rexp[0] = 32'hFF22_FF44;
    do_read(4'd6, 16'h0020, 8'd0, 2'b01, -1);

    // FIXED burst keeps hitting 0x8; last beat wins
    wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3;
    do_write(4'd7, 16'h0008, 8'd2, 2'b00, 4'hF);
    rexp[0] = 32'd3;
    do_read(4'd4, 16'h0008, 8'd0, 2'b01, -1);

    // Aliasing: 0x0410 is word 0x104 -> wraps to word 4 (address 0x10)
    rexp[0] = 32'hA0; rexp[1] = 32'hA1;
    do_read(4'd9, 16'h0410, 8'd1, 2'b01, -1);

    // Backpressure: stall mid-burst and on the last beat
    rexp[0] = 32'hA0; rexp[1] = 32'hA1; rexp[2] = 32'hA2; rexp[3] = 32'hA3;
    do_read(4'd8, 16'h0010, 8'd3, 2'b01, 1);
    do_read(4'd8, 16'h0010, 8'd3, 2'b01, 3);

    // Same-cycle write and read of one word: old data now, new data next cycle
    wd[0] = 32'h1234_5678;
    do_write(4'd1, 16'h0030, 8'd0, 2'b01, 4'hF);
    bus.arid = 4'd2; bus.araddr = 16'h0030; bus.arlen = 8'd0; bus.arsize = 3'd2;
    bus.arburst = 2'b01; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    bus.awid = 4'd1; bus.awaddr = 16'h0030; bus.awlen = 8'd0; bus.awsize = 3'd2;
    bus.awburst = 2'b01; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'hCAFE_BABE; bus.wstrb = 4'hF;
    check("rw_same_pre", bus.rdata, 32'h1234_5678);
    tick();
    bus.wvalid = 1'b0;
    check("rw_same_post", bus.rdata, 32'hCAFE_BABE);
    check("rw_bvalid", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    check("rw_rvalid_done", 32'(bus.rvalid), 32'd0);
    check("rw_bvalid_done", 32'(bus.bvalid), 32'd0);

    // Reset during W_DATA after one of four beats
    wd[0] = 32'h5555_5555; wd[1] = 32'h5555_5555; wd[2] = 32'h5555_5555; wd[3] = 32'h5555_5555;
    do_write(4'd1, 16'h0040, 8'd3, 2'b01, 4'hF);
    bus.awid = 4'd6; bus.awaddr = 16'h0040; bus.awlen = 8'd3; bus.awsize = 3'd2;
    bus.awburst = 2'b01; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'hB0; bus.wstrb = 4'hF;
    tick();
    bus.wdata = 32'hB1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_awready", 32'(bus.awready), 32'd1);
    check("mid_rst_wready", 32'(bus.wready), 32'd0);
    check("mid_rst_bid", 32'(bus.bid), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.wvalid = 1'b0;
    tick();
    check("post_rst_awready", 32'(bus.awready), 32'd1);
    check("post_rst_bvalid", 32'(bus.bvalid), 32'd0);
`ifdef AXI_RAM_SLAVE_MEM_RESET_EN
    rexp[0] = 32'h0; rexp[1] = 32'h0; rexp[2] = 32'h0; rexp[3] = 32'h0;
`else
    rexp[0] = 32'hB0; rexp[1] = 32'h5555_5555; rexp[2] = 32'h5555_5555; rexp[3] = 32'h5555_5555;
`endif
    do_read(4'd3, 16'h0040, 8'd3, 2'b01, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
